nway_dcache: RTL

Parametrised N-way set-associative, write-through, no-write-allocate data cache between the core's load/store unit and data memory. Tags are checked in the acceptance cycle. A miss is refilled over a valid/ready memory request channel plus a response strobe. Replacement is true LRU per set. The block keeps hit/miss performance counters and is the successor to the fixed 4-set, 2-way cache, which has no reset, no memory handshake and no store path.

---
 rtl/dcache_pkg.sv | 65 ++++++
 rtl/dcache_lru.sv | 65 ++++++
 rtl/nway_dcache.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the set-associative data cache.
// The DATA_ADDR_MODE_* encodings are the core's existing load/store size codes.
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_B  3'b000
`define DATA_ADDR_MODE_H  3'b001
`define DATA_ADDR_MODE_W  3'b010
`define DATA_ADDR_MODE_BU 3'b100
`define DATA_ADDR_MODE_HU 3'b101
`endif

package dcache_pkg;

    localparam logic [2:0] MODE_B  = `DATA_ADDR_MODE_B;
    localparam logic [2:0] MODE_H  = `DATA_ADDR_MODE_H;
    localparam logic [2:0] MODE_W  = `DATA_ADDR_MODE_W;
    localparam logic [2:0] MODE_BU = `DATA_ADDR_MODE_BU;
    localparam logic [2:0] MODE_HU = `DATA_ADDR_MODE_HU;

    typedef enum logic [1:0] {
        StIdle,
        StMissReq,
        StMissWait,
        StWrReq
    } dcache_state_e;

    // Tag is held zero-extended to 32 bits so the struct is parameter-free.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] data;
    } dcache_line_t;

    function automatic logic [3:0] byte_en(input logic [2:0] mode, input logic [1:0] off);
        case (mode)
            MODE_H, MODE_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
            MODE_B, MODE_BU: byte_en = 4'b0001 << off;
            default:         byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lane(input logic [2:0] mode, input logic [1:0] off,
                                               input logic [31:0] wdata);
        case (mode)
            MODE_H, MODE_HU: store_lane = off[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
            MODE_B, MODE_BU: store_lane = {24'h0, wdata[7:0]} << {off, 3'b000};
            default:         store_lane = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        b_sh = word >> {off, 3'b000};
        h_sh = word >> {off[1], 4'b0000};
        case (mode)
            MODE_B:  load_ext = {{24{b_sh[7]}}, b_sh[7:0]};
            MODE_BU: load_ext = {24'h0, b_sh[7:0]};
            MODE_H:  load_ext = {{16{h_sh[15]}}, h_sh[15:0]};
            MODE_HU: load_ext = {16'h0, h_sh[15:0]};
            default: load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age array: per-set ages, victim selection and touch update.
// Ages in a set always form a permutation of 0..NUM_WAYS-1.
module dcache_lru #(
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned NUM_WAYS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_SETS)-1:0] victim_set,
    input  logic [NUM_WAYS-1:0]         way_valid,
    output logic [$clog2(NUM_WAYS)-1:0] victim,
    input  logic                        touch,
    input  logic [$clog2(NUM_SETS)-1:0] touch_set,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way
);

    localparam int unsigned WAY_W = $clog2(NUM_WAYS);

    logic [WAY_W-1:0] ages_q [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] max_age;
    logic [WAY_W-1:0] old_age;
    logic             found;

    // Lowest-index invalid way wins; otherwise the oldest way.
    always_comb begin
        victim  = '0;
        found   = 1'b0;
        max_age = ages_q[victim_set][0];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!way_valid[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 1; w < NUM_WAYS; w++) begin
                if (ages_q[victim_set][w] > max_age) begin
                    max_age = ages_q[victim_set][w];
                    victim  = WAY_W'(w);
                end
            end
        end
    end

    assign old_age = ages_q[touch_set][touch_way];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    ages_q[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    ages_q[touch_set][w] <= '0;
                end else if (ages_q[touch_set][w] < old_age) begin
                    ages_q[touch_set][w] <= ages_q[touch_set][w] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nway_dcache.sv
// N-way set-associative, write-through, no-write-allocate data cache with
// valid/ready refill channel and saturating hit/miss counters.
module nway_dcache
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 4,
    parameter int unsigned NUM_WAYS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic [31:0]           total_accesses,
    output logic [31:0]           total_hits,
    output logic [31:0]           total_misses
);

    localparam int unsigned SET_W = $clog2(NUM_SETS);
    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = ADDR_WIDTH - 2 - SET_W;

    dcache_state_e         state_q, state_d;
    dcache_line_t          lines_q [NUM_SETS][NUM_WAYS];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            mode_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  rsp_valid_d;
    logic [31:0]           rsp_rdata_d;

    logic [SET_W-1:0]      req_set, set_q;
    logic [TAG_W-1:0]      req_tag;
    logic [3:0]            req_be;
    logic [31:0]           req_lane;
    logic                  accept, hit, load_hit, store_hit, fill;
    logic [WAY_W-1:0]      hit_way, victim;
    logic [NUM_WAYS-1:0]   way_valid;

    assign req_set  = req_addr[2 +: SET_W];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign set_q    = addr_q[2 +: SET_W];
    assign req_be   = byte_en(req_mode, req_addr[1:0]);
    assign req_lane = store_lane(req_mode, req_addr[1:0], req_wdata);

    assign accept    = req_valid && (state_q == StIdle);
    assign load_hit  = accept && !req_we && hit;
    assign store_hit = accept && req_we && hit;
    assign fill      = (state_q == StMissWait) && mem_rsp_valid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (lines_q[req_set][w].valid && lines_q[req_set][w].tag == 32'(req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_valid[w] = lines_q[set_q][w].valid;
        end
    end

    dcache_lru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .victim_set (set_q),
        .way_valid  (way_valid),
        .victim     (victim),
        .touch      (load_hit || store_hit || fill),
        .touch_set  (fill ? set_q : req_set),
        .touch_way  (fill ? victim : hit_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_we)    state_d = StWrReq;
                    else if (!hit) state_d = StMissReq;
                end
            end
            StMissReq:  if (mem_req_ready) state_d = StMissWait;
            StMissWait: if (mem_rsp_valid) state_d = StIdle;
            StWrReq:    if (mem_req_ready) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == StIdle);
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        unique case (state_q)
            StMissReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_req_be    = 4'b1111;
            end
            StWrReq: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_req_wdata = wdata_q;
                mem_req_be    = be_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        if (load_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_ext(req_mode, req_addr[1:0], lines_q[req_set][hit_way].data);
        end else if (fill) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_ext(mode_q, addr_q[1:0], mem_rsp_rdata);
        end else if ((state_q == StWrReq) && mem_req_ready) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            mode_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                mode_q  <= req_mode;
                wdata_q <= req_lane;
                be_q    <= req_be;
            end
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

    // Store hits merge their bytes at acceptance; fills replace the whole victim line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    lines_q[s][w] <= '0;
                end
            end
        end else if (fill) begin
            lines_q[set_q][victim] <= '{valid: 1'b1,
                                        tag:   32'(addr_q[ADDR_WIDTH-1 -: TAG_W]),
                                        data:  mem_rsp_rdata};
        end else if (store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) lines_q[req_set][hit_way].data[8*b +: 8] <= req_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_accesses <= '0;
            total_hits     <= '0;
            total_misses   <= '0;
        end else if (accept) begin
            if (total_accesses != '1) total_accesses <= total_accesses + 1'b1;
            if (hit) begin
                if (total_hits != '1) total_hits <= total_hits + 1'b1;
            end else begin
                if (total_misses != '1) total_misses <= total_misses + 1'b1;
            end
        end
    end

endmodule
